mem_arbiter: RTL and testbench

- Arbitrates one shared single-port synchronous memory between the core's instruction-fetch port and its data port.
- Sits between mips_core and a unified memory, replacing the split inst_rom/data_ram pair.
- Sequences each access through a fixed-latency memory cycle and produces the per-port stall signals the core already consumes.
- Fair round-robin between ports on simultaneous requests; writes are never torn.

---
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between
// the instruction-fetch port and the data port of the core.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_ren,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic                  rom_stall,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  ram_stall,
  output logic                  ext_cs,
  output logic                  ext_we,
  output logic [ADDR_WIDTH-1:0] ext_addr,
  output logic [DATA_WIDTH-1:0] ext_din,
  input  logic [DATA_WIDTH-1:0] ext_dout,
  output logic                  busy
);

  // state  | meaning
  // IDLE   | no access in flight; arbitrates and grants one port
  // ACCESS | ext_cs held for MEM_LATENCY cycles; ext_dout captured on the last
  // DONE   | one-cycle completion window; owner's stall is released
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_INST = 1'b0;
  localparam logic PORT_DATA = 1'b1;
  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_t     state;
  logic       owner;
  logic       last_grant;
  logic [3:0] counter;

  logic inst_req;
  logic data_req;
  logic grant_data;

  assign inst_req = inst_ren;
  assign data_req = mem_ren | mem_wen;

  // On a tie the port that did not win last time gets the memory.
  assign grant_data = data_req & (~inst_req | (last_grant == PORT_INST));

  assign rom_stall = inst_req & ~((state == DONE) && (owner == PORT_INST));
  assign ram_stall = data_req & ~((state == DONE) && (owner == PORT_DATA));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= PORT_INST;
      last_grant <= PORT_INST;
      counter    <= 4'd0;
      ext_cs     <= 1'b0;
      ext_we     <= 1'b0;
      ext_addr   <= '0;
      ext_din    <= '0;
      inst_data  <= '0;
      mem_din    <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inst_req || data_req) begin
            owner      <= grant_data;
            last_grant <= grant_data;
            ext_addr   <= grant_data ? mem_addr : inst_addr;
            ext_din    <= grant_data ? mem_dout : '0;
            ext_we     <= grant_data & mem_wen;
            ext_cs     <= 1'b1;
            busy       <= 1'b1;
            counter    <= LAT_M1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (counter == 4'd0) begin
            if (owner == PORT_INST) begin
              inst_data <= ext_dout;
            end else if (!ext_we) begin
              mem_din <= ext_dout;
            end
            ext_cs <= 1'b0;
            ext_we <= 1'b0;
            state  <= DONE;
          end else begin
            counter <= counter - 4'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ext_cs <= 1'b0;
          ext_we <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// cycle by cycle against a transaction-level timing model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_ren = 1'b0;
  logic        mem_ren = 1'b0;
  logic        mem_wen = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_dout = '0;

  logic [31:0] inst_data, mem_din, ext_addr, ext_din, ext_dout;
  logic        rom_stall, ram_stall, ext_cs, ext_we, busy;
  logic [31:0] inst_data_a, mem_din_a, ext_addr_a, ext_din_a, ext_dout_a;
  logic        rom_stall_a, ram_stall_a, ext_cs_a, ext_we_a, busy_a;
  logic [31:0] inst_data_b, mem_din_b, ext_addr_b, ext_din_b, ext_dout_b;
  logic        rom_stall_b, ram_stall_b, ext_cs_b, ext_we_b, busy_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(L)) u_dut (
    .clk(clk), .rst(rst),
    .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data), .rom_stall(rom_stall),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .ram_stall(ram_stall),
    .ext_cs(ext_cs), .ext_we(ext_we), .ext_addr(ext_addr), .ext_din(ext_din),
    .ext_dout(ext_dout), .busy(busy)
  );

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) u_dut_lat1 (
    .clk(clk), .rst(rst),
    .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data_a), .rom_stall(rom_stall_a),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din_a), .ram_stall(ram_stall_a),
    .ext_cs(ext_cs_a), .ext_we(ext_we_a), .ext_addr(ext_addr_a), .ext_din(ext_din_a),
    .ext_dout(ext_dout_a), .busy(busy_a)
  );

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(15)) u_dut_lat15 (
    .clk(clk), .rst(rst),
    .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data_b), .rom_stall(rom_stall_b),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din_b), .ram_stall(ram_stall_b),
    .ext_cs(ext_cs_b), .ext_we(ext_we_b), .ext_addr(ext_addr_b), .ext_din(ext_din_b),
    .ext_dout(ext_dout_b), .busy(busy_b)
  );

  // Memory responder: read data is only valid on the last cycle of the
  // latency window, anything earlier returns a recognisable junk pattern.
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic [4:0]  cnt, cnt_a, cnt_b;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    mem[16] <= 32'h2402_000A;
  end

  always @(posedge clk) begin
    if (ext_cs && ext_we) mem[ext_addr[5:0]] <= ext_din;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0; cnt_a <= '0; cnt_b <= '0;
    end else begin
      cnt   <= ext_cs   ? cnt + 5'd1   : 5'd0;
      cnt_a <= ext_cs_a ? cnt_a + 5'd1 : 5'd0;
      cnt_b <= ext_cs_b ? cnt_b + 5'd1 : 5'd0;
    end
  end

  assign ext_dout   = (ext_cs   && cnt   == 5'(L - 1)) ? mem[ext_addr[5:0]]   : (32'hBAD0_0000 | 32'(cnt));
  assign ext_dout_a = (ext_cs_a && cnt_a == 5'd0)      ? mem[ext_addr_a[5:0]] : (32'hBAD0_0000 | 32'(cnt_a));
  assign ext_dout_b = (ext_cs_b && cnt_b == 5'd14)     ? mem[ext_addr_b[5:0]] : (32'hBAD0_0000 | 32'(cnt_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a granted access occupies cycles k=0..L+1
  // counted from its grant cycle; the memory is busy for k=1..L+1.
  initial begin : model
    int   n;
    int   gc;
    int   k;
    bit   active;
    bit   own;
    bit   last;
    bit   wr;
    bit   ireq, dreq;
    logic [31:0] a, d, e_inst, e_din;
    n = 0; gc = 0; k = 0; active = 0; own = 0; last = 0; wr = 0;
    a = '0; d = '0; e_inst = '0; e_din = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0; last = 0; e_inst = '0; e_din = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
      end else begin
        ireq = inst_ren;
        dreq = mem_ren | mem_wen;
        if (!active) begin
          chkb("m_idle_busy", busy, 1'b0);
          chkb("m_idle_cs", ext_cs, 1'b0);
          chkb("m_idle_we", ext_we, 1'b0);
          chkb("m_idle_rom_stall", rom_stall, ireq);
          chkb("m_idle_ram_stall", ram_stall, dreq);
          if (ireq || dreq) begin
            own = (ireq && dreq) ? !last : dreq;
            last = own;
            active = 1;
            gc = n;
            wr = own && mem_wen;
            a = own ? mem_addr : inst_addr;
            d = mem_dout;
          end
        end else begin
          k = n - gc;
          if (k == L + 1) begin
            if (!own) e_inst = ref_mem[a[5:0]];
            else if (wr) ref_mem[a[5:0]] = d;
            else e_din = ref_mem[a[5:0]];
          end
          chkb("m_busy", busy, 1'b1);
          chkb("m_cs", ext_cs, k <= L);
          chkb("m_we", ext_we, wr && (k <= L));
          chk("m_addr", ext_addr, a);
          if (wr) chk("m_wdata", ext_din, d);
          chkb("m_rom_stall", rom_stall, ireq && !(k == L + 1 && !own));
          chkb("m_ram_stall", ram_stall, dreq && !(k == L + 1 && own));
          if (k == L + 1) active = 0;
        end
        chk("m_inst_data", inst_data, e_inst);
        chk("m_mem_din", mem_din, e_din);
        n++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  initial begin : stim
    bit i_done, d_done;
    logic [1:0] r;
    i_done = 0; d_done = 0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // Single read on all three latencies.
    for (int c = 0; c <= 17; c++) begin
      cyc();
      if (c == 0) begin inst_ren = 1'b1; inst_addr = 32'h10; end
      if (c == 17) inst_ren = 1'b0;
      #2;
      if (c == 0) chk("rst_inst_data", inst_data, 32'h0);
      if (c <= 3) begin
        chkb("rd_rom_stall", rom_stall, c < 3);
        chkb("rd_ext_cs", ext_cs, c == 1 || c == 2);
      end
      if (c == 3) chk("rd_inst_data", inst_data, 32'h2402_000A);
      if (c == 1) chkb("lat1_stall_hi", rom_stall_a, 1'b1);
      if (c == 2) begin
        chkb("lat1_stall_lo", rom_stall_a, 1'b0);
        chk("lat1_data", inst_data_a, 32'h2402_000A);
      end
      if (c == 15) chkb("lat15_stall_hi", rom_stall_b, 1'b1);
      if (c == 16) begin
        chkb("lat15_stall_lo", rom_stall_b, 1'b0);
        chk("lat15_data", inst_data_b, 32'h2402_000A);
      end
    end
    repeat (4) cyc();
    #2;
    chkb("lat_busy_a", busy_a, 1'b0);
    chkb("lat_busy_b", busy_b, 1'b0);
    chkb("lat_cs_a", ext_cs_a, 1'b0);
    chkb("lat_cs_b", ext_cs_b, 1'b0);
    chkb("lat_we_a", ext_we_a, 1'b0);
    chkb("lat_we_b", ext_we_b, 1'b0);
    chkb("lat_ram_stall_a", ram_stall_a, 1'b0);
    chkb("lat_ram_stall_b", ram_stall_b, 1'b0);
    chk("lat_addr_a", ext_addr_a, 32'h10);
    chk("lat_addr_b", ext_addr_b, 32'h10);
    chk("lat_din_a", ext_din_a, 32'h0);
    chk("lat_din_b", ext_din_b, 32'h0);
    chk("lat_mem_din_a", mem_din_a, 32'h0);
    chk("lat_mem_din_b", mem_din_b, 32'h0);

    // Single write.
    reset_pulse();
    for (int c = 0; c <= 4; c++) begin
      cyc();
      if (c == 0) begin mem_wen = 1'b1; mem_addr = 32'h20; mem_dout = 32'hDEAD_BEEF; end
      if (c == 4) mem_wen = 1'b0;
      #2;
      if (c == 0) chkb("rst_busy", busy, 1'b0);
      if (c == 1 || c == 2) begin
        chkb("wr_we", ext_we, 1'b1);
        chkb("wr_cs", ext_cs, 1'b1);
        chk("wr_addr", ext_addr, 32'h20);
        chk("wr_din", ext_din, 32'hDEAD_BEEF);
      end
      if (c <= 3) chkb("wr_ram_stall", ram_stall, c < 3);
      if (c == 3) begin
        chkb("wr_done_cs", ext_cs, 1'b0);
        chk("wr_mem_din", mem_din, 32'h0);
      end
    end

    // First tie after reset goes to the data port.
    reset_pulse();
    for (int c = 0; c <= 9; c++) begin
      cyc();
      if (c == 0) begin
        inst_ren = 1'b1; inst_addr = 32'h10;
        mem_ren = 1'b1; mem_addr = 32'h21;
      end
      if (c == 4) mem_ren = 1'b0;
      if (c == 8) inst_ren = 1'b0;
      #2;
      if (c == 3) begin
        chkb("tie_ram_stall", ram_stall, 1'b0);
        chkb("tie_rom_wait", rom_stall, 1'b1);
        chk("tie_mem_din", mem_din, 32'h3121_2121);
      end
      if (c == 6) chkb("tie_rom_stall6", rom_stall, 1'b1);
      if (c == 7) begin
        chkb("tie_rom_stall7", rom_stall, 1'b0);
        chk("tie_inst_data", inst_data, 32'h2402_000A);
      end
    end

    // Continuous contention alternates, starting with data.
    for (int c = 0; c <= 24; c++) begin
      cyc();
      if (c == 0) begin
        inst_ren = 1'b1; inst_addr = 32'h11;
        mem_ren = 1'b1; mem_addr = 32'h22;
      end
      if (c == 24) begin inst_ren = 1'b0; mem_ren = 1'b0; end
      #2;
      if (c % 4 == 3) begin
        chkb("alt_ram_stall", ram_stall, ((c / 4) % 2) == 1);
        chkb("alt_rom_stall", rom_stall, ((c / 4) % 2) == 0);
      end
    end

    // Reset in the middle of a write.
    reset_pulse();
    cyc();
    mem_wen = 1'b1; mem_addr = 32'h05; mem_dout = 32'h1234_5678;
    cyc();
    #2;
    chkb("rstw_cs_before", ext_cs, 1'b1);
    rst = 1'b1;
    #1;
    chkb("rstw_cs_async", ext_cs, 1'b0);
    chkb("rstw_we_async", ext_we, 1'b0);
    chkb("rstw_busy_async", busy, 1'b0);
    mem_wen = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    cyc();
    #2;
    chkb("rstw_busy_after", busy, 1'b0);
    chkb("rstw_cs_after", ext_cs, 1'b0);

    // Randomized traffic; each port holds its request until it completes.
    for (int c = 0; c < 1500; c++) begin
      cyc();
      if (!inst_ren || i_done) begin
        inst_ren  = 1'($urandom_range(0, 1));
        inst_addr = 32'($urandom_range(0, 63));
      end
      if (!(mem_ren || mem_wen) || d_done) begin
        r        = 2'($urandom_range(0, 3));
        mem_ren  = r[0];
        mem_wen  = r[1];
        mem_addr = 32'($urandom_range(0, 63));
        mem_dout = $urandom;
      end
      #2;
      i_done = inst_ren && !rom_stall;
      d_done = (mem_ren || mem_wen) && !ram_stall;
    end
    cyc();
    inst_ren = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
    repeat (6) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
